// File: rtl/zigzag_scan_4x4.sv
// Zigzag reordering of a captured 4x4 quantized block into a 16-beat valid/ready stream,
// with a nonzero-coefficient count registered alongside the buffer.
module zigzag_scan_4x4 #(
  parameter int unsigned BIT_LENGTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH:0]   coeffs [16],
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIT_LENGTH:0]   out_coeff,
  output logic [3:0]            out_index,
  output logic                  out_last,
  output logic [4:0]            total_coeff,
  output logic                  zero_block
);

  localparam int unsigned NUM_COEFFS = 16;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned TOTAL_W    = 5;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [BIT_LENGTH:0]    buffer [NUM_COEFFS];
  logic [CNT_W-1:0]       cnt;
  logic                   xfer;
  logic                   last_xfer;
  logic                   capture;
  logic [TOTAL_W-1:0]     nz_count;

  // Raster position of each zigzag scan position.
  function automatic logic [CNT_W-1:0] zz_pos(input logic [CNT_W-1:0] k);
    case (k)
      4'd0:    zz_pos = 4'd0;
      4'd1:    zz_pos = 4'd1;
      4'd2:    zz_pos = 4'd4;
      4'd3:    zz_pos = 4'd8;
      4'd4:    zz_pos = 4'd5;
      4'd5:    zz_pos = 4'd2;
      4'd6:    zz_pos = 4'd3;
      4'd7:    zz_pos = 4'd6;
      4'd8:    zz_pos = 4'd9;
      4'd9:    zz_pos = 4'd12;
      4'd10:   zz_pos = 4'd13;
      4'd11:   zz_pos = 4'd10;
      4'd12:   zz_pos = 4'd7;
      4'd13:   zz_pos = 4'd11;
      4'd14:   zz_pos = 4'd14;
      default: zz_pos = 4'd15;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Handshakes and next state; the last-beat cycle also accepts a new block.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    last_xfer = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = enable && !reset;
      end
      SCAN: begin
        out_valid = enable && !reset;
        xfer      = out_valid && out_ready;
        last_xfer = xfer && (cnt == CNT_W'(NUM_COEFFS - 1));
        in_ready  = last_xfer;
        if (last_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    capture = in_ready && in_valid;
    if (capture) state_nxt = SCAN;
  end

  always_comb begin
    nz_count = '0;
    for (int i = 0; i < int'(NUM_COEFFS); i++)
      nz_count = nz_count + TOTAL_W'(coeffs[i] != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      total_coeff <= '0;
      for (int i = 0; i < int'(NUM_COEFFS); i++) buffer[i] <= '0;
    end else if (capture) begin
      cnt         <= '0;
      total_coeff <= nz_count;
      for (int i = 0; i < int'(NUM_COEFFS); i++) buffer[i] <= coeffs[i];
    end else if (xfer) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_coeff  = buffer[zz_pos(cnt)];
  assign out_index  = cnt;
  assign out_last   = (state == SCAN) && (cnt == CNT_W'(NUM_COEFFS - 1));
  assign zero_block = (total_coeff == '0);

endmodule

// File: tb/tb_zigzag_scan_4x4.sv
// Bench for zigzag_scan_4x4: table vectors, random blocks and a cycle-level reference model.
module tb_zigzag_scan_4x4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] coeffs [16];
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_coeff;
  logic [3:0]  out_index;
  logic        out_last;
  logic [4:0]  total_coeff;
  logic        zero_block;

  zigzag_scan_4x4 #(.BIT_LENGTH(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .coeffs(coeffs), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_coeff(out_coeff), .out_index(out_index),
    .out_last(out_last), .total_coeff(total_coeff), .zero_block(zero_block)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0] blk;
    logic [4:0]   exp_total;
    logic [15:0]  exp_b0;
    logic [15:0]  exp_b4;
    logic [15:0]  exp_b15;
  } vec_t;

  typedef struct packed {
    logic [15:0] coeff;
    logic [3:0]  idx;
    logic        last;
    logic [4:0]  total;
    logic        zb;
    int          cyc;
  } beat_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  int    rdy_mode = 0;
  int    zz_tab [16];
  vec_t  tbl [4];
  beat_t obs [$];

  // Reference model state
  bit          m_busy = 0;
  int          m_cnt = 0;
  int          m_total = 0;
  logic [15:0] m_buf [16];
  bit          m_captured = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor_cycle();
    bit exp_ov, exp_last_xfer, exp_ir;
    beat_t b;
    m_captured = 0;
    if (reset) begin
      m_busy = 0; m_cnt = 0; m_total = 0;
      return;
    end
    exp_ov        = enable && m_busy;
    exp_last_xfer = exp_ov && out_ready && (m_cnt == 15);
    exp_ir        = enable && (!m_busy || exp_last_xfer);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_last", 32'(out_last), 32'(m_busy && m_cnt == 15));
    chk("total_coeff", 32'(total_coeff), 32'(m_total));
    chk("zero_block", 32'(zero_block), 32'(m_total == 0));
    if (m_busy) begin
      chk("out_coeff", 32'(out_coeff), 32'(m_buf[zz_tab[m_cnt]]));
      chk("out_index", 32'(out_index), 32'(m_cnt));
    end
    if (out_valid && out_ready && enable) begin
      b.coeff = out_coeff; b.idx = out_index; b.last = out_last;
      b.total = total_coeff; b.zb = zero_block; b.cyc = cyc;
      obs.push_back(b);
    end
    if (exp_ov && out_ready) begin
      m_cnt++;
      if (m_cnt == 16) begin m_busy = 0; m_cnt = 0; end
    end
    if (exp_ir && in_valid) begin
      m_busy = 1; m_cnt = 0; m_total = 0; m_captured = 1;
      for (int i = 0; i < 16; i++) begin
        m_buf[i] = coeffs[i];
        if (coeffs[i] != 16'd0) m_total++;
      end
    end
  endtask

  // One clock: model/check at the falling edge, new out_ready just after the rising edge.
  task automatic step();
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       out_ready = pat[cyc % 4];
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic drive_block(input logic [255:0] b);
    bit done;
    done = 0;
    for (int i = 0; i < 16; i++) coeffs[i] = b[i*16 +: 16];
    in_valid = 1'b1;
    for (int t = 0; t < 400 && !done; t++) begin
      step();
      if (m_captured) done = 1;
    end
    in_valid = 1'b0;
    chk("capture_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    for (int t = 0; t < 1000 && obs.size() < n; t++) step();
    chk("beat_timeout", 32'(obs.size() >= n), 32'd1);
  endtask

  task automatic wait_index(input int idx, output bit ok);
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (out_valid && out_index == 4'(idx)) ok = 1;
      else step();
    end
    chk("index_timeout", 32'(ok), 32'd1);
  endtask

  function automatic logic [255:0] rand_block();
    logic [255:0] b;
    logic [31:0]  r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom;
      b[i*16 +: 16] = r[0] ? r[31:16] : 16'd0;
    end
    return b;
  endfunction

  task automatic check_indices(input int base);
    for (int k = 0; k < 16; k++)
      chk("beat_index", 32'(obs[base + k].idx), 32'(k));
  endtask

  initial begin
    int k;
    k = 0;
    for (int s = 0; s <= 6; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 3 ? s : 3); r >= (s > 3 ? s - 3 : 0); r--) begin
          zz_tab[k] = r * 4 + (s - r); k++;
        end
      end else begin
        for (int r = (s > 3 ? s - 3 : 0); r <= (s < 3 ? s : 3); r++) begin
          zz_tab[k] = r * 4 + (s - r); k++;
        end
      end
    end
  end

  initial begin
    int    base;
    bit    ok;
    int    exp_seq [16];
    logic [255:0] ba;
    exp_seq = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};

    for (int i = 0; i < 16; i++) tbl[0].blk[i*16 +: 16] = 16'(i + 1);
    tbl[0].exp_total = 5'd16; tbl[0].exp_b0 = 16'd1; tbl[0].exp_b4 = 16'd6; tbl[0].exp_b15 = 16'd16;
    tbl[1].blk = '0; tbl[1].blk[15:0] = 16'hFFFD; tbl[1].blk[5*16 +: 16] = 16'd2;
    tbl[1].exp_total = 5'd2; tbl[1].exp_b0 = 16'hFFFD; tbl[1].exp_b4 = 16'd2; tbl[1].exp_b15 = 16'd0;
    tbl[2].blk = '0;
    tbl[2].exp_total = 5'd0; tbl[2].exp_b0 = 16'd0; tbl[2].exp_b4 = 16'd0; tbl[2].exp_b15 = 16'd0;
    tbl[3].blk = '0; tbl[3].blk[15*16 +: 16] = 16'h8000; tbl[3].blk[3*16 +: 16] = 16'h7FFF;
    tbl[3].exp_total = 5'd2; tbl[3].exp_b0 = 16'd0; tbl[3].exp_b4 = 16'd0; tbl[3].exp_b15 = 16'h8000;

    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) coeffs[i] = 16'h5A5A;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_coeff", 32'(out_coeff), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_total", 32'(total_coeff), 32'd0);
    chk("rst_zero_block", 32'(zero_block), 32'd1);
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 4; v++) begin
      base = obs.size();
      drive_block(tbl[v].blk);
      wait_beats(base + 16);
      if (obs.size() >= base + 16) begin
        chk("tbl_total", 32'(obs[base].total), 32'(tbl[v].exp_total));
        chk("tbl_zero_block", 32'(obs[base].zb), 32'(tbl[v].exp_total == 0));
        chk("tbl_beat0", 32'(obs[base].coeff), 32'(tbl[v].exp_b0));
        chk("tbl_beat4", 32'(obs[base + 4].coeff), 32'(tbl[v].exp_b4));
        chk("tbl_beat15", 32'(obs[base + 15].coeff), 32'(tbl[v].exp_b15));
        chk("tbl_last", 32'(obs[base + 15].last), 32'd1);
        if (v == 0)
          for (int j = 0; j < 16; j++) begin
            chk("order_coeff", 32'(obs[base + j].coeff), 32'(exp_seq[j]));
            chk("order_last", 32'(obs[base + j].last), 32'(j == 15));
          end
        if (v == 2)
          for (int j = 0; j < 16; j++) chk("zero_beat", 32'(obs[base + j].coeff), 32'd0);
      end
      step();
    end

    // Back-to-back blocks: 32 beats on consecutive cycles
    base = obs.size();
    drive_block(rand_block());
    drive_block(rand_block());
    wait_beats(base + 32);
    if (obs.size() >= base + 32) begin
      chk("b2b_span", 32'(obs[base + 31].cyc - obs[base].cyc), 32'd31);
      chk("b2b_idx16", 32'(obs[base + 16].idx), 32'd0);
    end
    step(); step();

    // Backpressure: fixed 1,0,0,1 then random out_ready
    for (int n = 0; n < 7; n++) begin
      rdy_mode = (n < 3) ? 1 : 2;
      base = obs.size();
      drive_block(rand_block());
      wait_beats(base + 16);
      if (obs.size() >= base + 16) check_indices(base);
      step();
    end
    rdy_mode = 0;
    step();

    // Enable stall at index 7
    base = obs.size();
    drive_block(rand_block());
    wait_index(7, ok);
    enable = 1'b0;
    repeat (5) step();
    chk("stall_valid", 32'(out_valid), 32'd0);
    chk("stall_index", 32'(out_index), 32'd7);
    enable = 1'b1;
    #1;
    chk("resume_valid", 32'(out_valid), 32'd1);
    chk("resume_index", 32'(out_index), 32'd7);
    wait_beats(base + 16);
    if (obs.size() >= base + 16) check_indices(base);
    step();

    // Reset in mid-scan at index 9
    ba = rand_block();
    ba[15:0] = 16'h1234;
    drive_block(rand_block());
    wait_index(9, ok);
    reset = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_total", 32'(total_coeff), 32'd0);
    chk("abort_zero_block", 32'(zero_block), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_index", 32'(out_index), 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("abort_rel_ready", 32'(in_ready), 32'd1);
    base = obs.size();
    drive_block(ba);
    wait_beats(base + 16);
    if (obs.size() >= base + 16) begin
      chk("post_rst_idx0", 32'(obs[base].idx), 32'd0);
      chk("post_rst_beat0", 32'(obs[base].coeff), 32'h1234);
      check_indices(base);
    end
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
